// File: rtl/maxnet_ctrl.sv
// MaxNet layer sequencer: time-shares one pu across 4 neurons until one winner remains.
// Optional iteration limit enabled by defining MAXNET_CTRL_ITER_LIMIT_EN.
module maxnet_ctrl #(
  parameter int unsigned DW       = 5,
  parameter int unsigned PU_LAT   = 1,
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned ITW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4*DW-1:0]  x_flat,
  input  logic [DW-1:0]    w_self,
  input  logic [DW-1:0]    w_other,
  output logic [4*DW-1:0]  pu_x,
  output logic [4*DW-1:0]  pu_w,
  input  logic [DW-1:0]    pu_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic             winner_vld,
  output logic             timeout,
  output logic [ITW-1:0]   iter_cnt,
  output logic [4*DW-1:0]  act_flat
);

  localparam int unsigned N  = 4;
  localparam int unsigned VW = N * DW;
  localparam int unsigned CW = (PU_LAT > 1) ? $clog2(PU_LAT) : 1;

  if (PU_LAT < 1) begin : g_bad_lat
    $error("PU_LAT must be at least 1");
  end
  if (MAX_ITER >= (1 << ITW)) begin : g_bad_itw
    $error("ITW too narrow for MAX_ITER");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT, S_DONE} state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [CW-1:0]   wcnt;
  logic [VW-1:0]   nxt;
  logic [DW-1:0]   ws, wo;
  logic [2:0]      nz_cnt;
  logic [1:0]      nz_idx;
`ifdef MAXNET_CTRL_ITER_LIMIT_EN
  logic            timeout_q;
  logic [1:0]      max_idx;
  logic [DW-1:0]   max_val;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Slot j of the pu sees neuron (base+j)%4, so x0 is always the neuron being updated.
  function automatic logic [VW-1:0] rot(input logic [VW-1:0] a, input logic [1:0] base);
    logic [VW-1:0] r;
    logic [1:0]    k;
    r = '0;
    for (int j = 0; j < N; j++) begin
      k = base + 2'(j);
      r[j*DW +: DW] = a[32'(k)*DW +: DW];
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] pack_w(input logic [DW-1:0] s, input logic [DW-1:0] o);
    return {o, o, o, s};
  endfunction

  // Survivor census over the freshly computed activations.
  always_comb begin
    nz_cnt = '0;
    nz_idx = '0;
`ifdef MAXNET_CTRL_ITER_LIMIT_EN
    max_idx = '0;
    max_val = '0;
`endif
    for (int k = 0; k < N; k++) begin
      if (|nxt[k*DW +: DW]) begin
        nz_cnt = nz_cnt + 3'd1;
        nz_idx = 2'(k);
      end
`ifdef MAXNET_CTRL_ITER_LIMIT_EN
      if (nxt[k*DW +: DW] > max_val) begin
        max_val = nxt[k*DW +: DW];
        max_idx = 2'(k);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      wcnt       <= '0;
      nxt        <= '0;
      ws         <= '0;
      wo         <= '0;
      pu_x       <= '0;
      pu_w       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      winner     <= '0;
      winner_vld <= 1'b0;
      iter_cnt   <= '0;
      act_flat   <= '0;
`ifdef MAXNET_CTRL_ITER_LIMIT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            act_flat   <= x_flat;
            ws         <= w_self;
            wo         <= w_other;
            iter_cnt   <= '0;
            idx        <= '0;
            winner_vld <= 1'b0;
            busy       <= 1'b1;
            pu_x       <= rot(x_flat, 2'd0);
            pu_w       <= pack_w(w_self, w_other);
`ifdef MAXNET_CTRL_ITER_LIMIT_EN
            timeout_q  <= 1'b0;
`endif
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == CW'(PU_LAT - 1)) begin
            nxt[32'(idx)*DW +: DW] <= pu_out;
            if (idx == 2'd3) begin
              state <= S_COMMIT;
            end else begin
              idx   <= idx + 2'd1;
              pu_x  <= rot(act_flat, idx + 2'd1);
              state <= S_ISSUE;
            end
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        S_COMMIT: begin
          act_flat <= nxt;
          iter_cnt <= iter_cnt + ITW'(1);
          idx      <= '0;
          if (nz_cnt <= 3'd1) begin
            state      <= S_DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            winner     <= nz_idx;
            winner_vld <= (nz_cnt == 3'd1);
            pu_x       <= '0;
            pu_w       <= '0;
          end
`ifdef MAXNET_CTRL_ITER_LIMIT_EN
          else if (iter_cnt + ITW'(1) == ITW'(MAX_ITER)) begin
            state      <= S_DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            timeout_q  <= 1'b1;
            winner     <= max_idx;
            winner_vld <= 1'b0;
            pu_x       <= '0;
            pu_w       <= '0;
          end
`endif
          else begin
            pu_x  <= rot(nxt, 2'd0);
            pu_w  <= pack_w(ws, wo);
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Scoreboard bench for maxnet_ctrl with a cycle-scripted pu model (PU_LAT=1).
module tb_maxnet_ctrl;

  localparam int unsigned DW  = 5;
  localparam int unsigned ITW = 4;
`ifdef MAXNET_CTRL_ITER_LIMIT_EN
  localparam int unsigned MAX_ITER = 3;
`else
  localparam int unsigned MAX_ITER = 15;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [4*DW-1:0]  x_flat;
  logic [DW-1:0]    w_self, w_other;
  logic [4*DW-1:0]  pu_x, pu_w;
  logic [DW-1:0]    pu_out;
  logic             busy, done, winner_vld, timeout;
  logic [1:0]       winner;
  logic [ITW-1:0]   iter_cnt;
  logic [4*DW-1:0]  act_flat;

  maxnet_ctrl #(.DW(DW), .PU_LAT(1), .MAX_ITER(MAX_ITER), .ITW(ITW)) dut (
    .clk(clk), .rst(rst), .start(start), .x_flat(x_flat), .w_self(w_self),
    .w_other(w_other), .pu_x(pu_x), .pu_w(pu_w), .pu_out(pu_out), .busy(busy),
    .done(done), .winner(winner), .winner_vld(winner_vld), .timeout(timeout),
    .iter_cnt(iter_cnt), .act_flat(act_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [1:0]      win;
    logic            vld;
    logic [ITW-1:0]  it;
    logic [4*DW-1:0] act;
    logic            to;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          run_cyc;
  logic [DW-1:0] scr [0:1][0:3];
  int          scr_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  // pu result for the cycle c after the start edge: iteration c/9, neuron (c%9)/2.
  function automatic logic [DW-1:0] pu_val(input int c);
    int i, r;
    if (c < 0) return '0;
    i = c / 9;
    r = c % 9;
    if (i >= scr_n) i = scr_n - 1;
    if (r >= 8) return '0;
    return scr[i][r/2];
  endfunction

  task automatic set_scr(input int n, input logic [4*DW-1:0] s0, input logic [4*DW-1:0] s1);
    scr_n = n;
    for (int k = 0; k < 4; k++) begin
      scr[0][k] = s0[k*DW +: DW];
      scr[1][k] = s1[k*DW +: DW];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    run_cyc++;
    pu_out = pu_val(run_cyc);
  endtask

  task automatic push_exp(input int iters, input int win, input bit vld,
                          input logic [4*DW-1:0] act, input bit to);
    exp_t e;
    e.cyc = 9 * iters; e.win = 2'(win); e.vld = vld; e.it = ITW'(iters);
    e.act = act; e.to = to;
    sb.push_back(e);
  endtask

  task automatic run(input logic [4*DW-1:0] x, input int ws, input int wo, input int budget,
                     input bit chk_issue, input bit repulse, output bit got_done);
    exp_t e;
    x_flat = x; w_self = DW'(ws); w_other = DW'(wo);
    run_cyc = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    got_done = 1'b0;
    while (!got_done && run_cyc < budget) begin
      step();
      if (repulse && run_cyc == 3) begin start = 1'b1; x_flat = '0; end
      if (repulse && run_cyc == 4) start = 1'b0;
      if (chk_issue && (run_cyc == 4 || run_cyc == 5)) begin
        chk("pu_x_n2", 32'(pu_x), 32'(pk(2, 1, 4, 6)));
        chk("pu_w_n2", 32'(pu_w), 32'(pk(8, 2, 2, 2)));
      end
      if (done) begin
        got_done = 1'b1;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(run_cyc), 32'(e.cyc));
          chk("busy_in_done", 32'(busy), 0);
          chk("winner", 32'(winner), 32'(e.win));
          chk("winner_vld", 32'(winner_vld), 32'(e.vld));
          chk("iter_cnt", 32'(iter_cnt), 32'(e.it));
          chk("act_flat", 32'(act_flat), 32'(e.act));
          chk("timeout", 32'(timeout), 32'(e.to));
          chk("pu_x_done", 32'(pu_x), 0);
          step();
          chk("done_pulse_len", 32'(done), 0);
          chk("winner_hold", 32'(winner), 32'(e.win));
        end
      end
    end
  endtask

  initial begin
    bit got;
    rst = 1'b0; start = 1'b0; x_flat = '0; w_self = '0; w_other = '0; pu_out = '0;
    run_cyc = -1;
    set_scr(1, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_act", 32'(act_flat), 0);
    chk("rst_pu_w", 32'(pu_w), 0);
    rst = 1'b1;
    step();

    // Reset asserted mid-run aborts without a done pulse.
    set_scr(1, pk(2, 5, 0, 0), pk(2, 5, 0, 0));
    x_flat = pk(4, 6, 2, 1); w_self = 5'd8; w_other = 5'd2;
    run_cyc = -1; start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pu_x", 32'(pu_x), 0);
    chk("abort_pu_w", 32'(pu_w), 0);
    chk("abort_act", 32'(act_flat), 0);
    chk("abort_iter", 32'(iter_cnt), 0);
    repeat (12) begin
      step();
      chk("abort_no_done", 32'(done), 0);
    end
    rst = 1'b1;
    step();

    // Two-iteration convergence to neuron 1, with operand check at neuron 2.
    set_scr(2, pk(2, 5, 0, 0), pk(0, 4, 0, 0));
    push_exp(2, 1, 1'b1, pk(0, 4, 0, 0), 1'b0);
    run(pk(4, 6, 2, 1), 8, 2, 60, 1'b1, 1'b0, got);
    chk("case2_done_seen", 32'(got), 1);
    step();

    // All-zero first iteration: no winner after one iteration.
    set_scr(1, pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    push_exp(1, 0, 1'b0, pk(0, 0, 0, 0), 1'b0);
    run(pk(3, 7, 1, 9), 6, 3, 60, 1'b0, 1'b0, got);
    chk("case4_done_seen", 32'(got), 1);

    // Start re-pulsed while busy (with x_flat changed) must not restart.
    set_scr(2, pk(2, 5, 0, 0), pk(0, 4, 0, 0));
    push_exp(2, 1, 1'b1, pk(0, 4, 0, 0), 1'b0);
    run(pk(4, 6, 2, 1), 8, 2, 60, 1'b1, 1'b1, got);
    chk("case5_done_seen", 32'(got), 1);

    // Persistent tie between neurons 0 and 1.
    set_scr(1, pk(3, 3, 0, 0), pk(3, 3, 0, 0));
`ifdef MAXNET_CTRL_ITER_LIMIT_EN
    push_exp(3, 0, 1'b0, pk(3, 3, 0, 0), 1'b1);
    run(pk(5, 5, 1, 1), 7, 1, 60, 1'b0, 1'b0, got);
    chk("case6_done_seen", 32'(got), 1);
`else
    run(pk(5, 5, 1, 1), 7, 1, 100, 1'b0, 1'b0, got);
    chk("tie_no_done", 32'(got), 0);
    chk("tie_busy_at_100", 32'(busy), 1);
    chk("tie_timeout", 32'(timeout), 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
`endif
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
